control_sequencer: RTL and testbench
====================================

# control_sequencer

Multi-cycle sequencer for the CPU control unit. It fetches and holds the current instruction and classifies its opcode into a format class. It steps the per-instruction micro-state through the existing class decoder bank and gates the selected control word so that PC advance and register/RAM writes happen only on the completing cycle. It sits between instruction memory, the class decoders and the datapath, and owns the only state register of the control unit.

## Interface
- `CW_W`, 29: control word width, `{Psel[28:27], DA[26:22], SA[21:17], SB[16:12], Fsel[11:7], regW[6], ramW[5], Dsel[4:3], Bsel[2], PCsel[1], SL[0]}`
- `clock`  in  1: sole clock; all state changes on rising edge
- `reset`  in  1: synchronous, active-high
- `instr_in`  in  32: instruction memory read data
- `instr_valid`  in  1: `instr_in` valid this cycle
- `fetch_req`  out  1: sequencer is waiting for an instruction
- `instruction`  out  32: registered IR, drives the decoder bank
- `op_class`  out  3: 0 ILLEGAL, 1 R-arith, 2 I-arith, 3 D (load/store), 4 B, 5 CB, 6 IW
- `state`  out  2: registered micro-state, drives the decoder bank
- `dec_cw`  in  29, `dec_ns`  in  2, `dec_k`  in  64: selected decoder bank outputs
- `mem_req`  out  1: data-RAM access in progress
- `mem_ready`  in  1: data RAM completes the access this cycle
- `controlWord`  out  29: gated control word to the datapath
- `K`  out  64: immediate to the datapath
- `halted`  out  1: sequencer is stopped on an illegal opcode

## Operation
- FSM states: FETCH, EXEC, MEMWAIT, HALT.
- FETCH:
  - `fetch_req`=1.
  - On `instr_valid`=1: IR <= `instr_in`, `state` <= 0, go to EXEC.
  - Otherwise stay in FETCH.
- Class decode is combinational from IR. The first match in this order wins:
  - I-arith: IR[28:23]=100010
  - IW: IR[28:23]=100101
  - D: IR[29:24]=111000
  - R: IR[28:25]=0101
  - B: IR[30:26]=00101
  - CB: IR[30:25]=011010
  - Anything else is ILLEGAL.
- A memory step is one where `dec_cw` has ramW=1 or Dsel=2'b10.
- EXEC, non-memory step:
  - `controlWord`=`dec_cw`, `K`=`dec_k`.
  - If `dec_ns`=0: go to FETCH.
  - Else: `state` <= `dec_ns` and stay in EXEC. Psel is forced to 00 on this cycle.
- EXEC, memory step: `mem_req`=1, regW/ramW/Psel forced to 0, go to MEMWAIT.
- MEMWAIT:
  - `mem_req`=1.
  - Outputs are gated as in EXEC until the cycle `mem_ready`=1.
  - On that cycle, `dec_cw` passes ungated (except Psel when `dec_ns`≠0), then apply the EXEC `dec_ns` transition.
- `mem_ready` in EXEC on the first cycle of a memory step is ignored.
- ILLEGAL class in EXEC: see Configuration.
- HALT: `controlWord`=0, `K`=0, `halted`=1. Only `reset` leaves HALT.
- In FETCH and HALT, `controlWord` and `K` are 0 (PC hold, no writes).

## Timing
- Reset values: FSM=FETCH, IR=0, `state`=0, `controlWord`=0, `K`=0, `mem_req`=0, `halted`=0, `fetch_req`=1.
- Single-step instruction: 1 FETCH cycle (with `instr_valid`) plus 1 EXEC cycle.
- An N-step instruction takes N EXEC cycles. Each memory step adds ≥1 MEMWAIT cycle.
- `instr_valid` is ignored outside FETCH. `mem_ready` is ignored outside MEMWAIT.
- Reset asserted mid-instruction or in MEMWAIT: outputs reach reset values after the next edge. No write is issued on that cycle.
- `dec_cw`/`dec_ns`/`dec_k` are sampled combinationally. No extra pipeline latency.

## Configuration
- `CU_ILLEGAL_TRAP_EN` defined:
  - ILLEGAL class in EXEC goes to HALT.
  - `halted` rises on the next edge.
  - No write or PC advance for that instruction.
- `CU_ILLEGAL_TRAP_EN` undefined:
  - ILLEGAL executes as a NOP: one EXEC cycle with `controlWord`={2'b01, 27'd0} (PC+4 only), `K`=0.
  - Then FETCH.
  - `halted` is tied to 0.

## Test plan
- Reset: hold `reset` 2 cycles -> `fetch_req`=1, `controlWord`=0, `K`=0, `halted`=0, `mem_req`=0.
- ADDI X1,X2,#5 = 0x91001441 with `instr_valid` -> `op_class`=2, `state`=0. On the EXEC cycle `controlWord` equals `dec_cw`, then back to FETCH.
- STUR X3,[X4,#8] = 0xF8008083, decoder ramW=1, `mem_ready` delayed 3 cycles -> `op_class`=3, `mem_req`=1 for 4 cycles, ramW=1 only on the `mem_ready` cycle.
- Two-step instruction (`dec_ns`=1 then 0) -> `state` goes 0 then 1, Psel=00 on the first step, Psel=`dec_cw` on the second.
- 0x00000000 -> trap build: `halted`=1 and `controlWord`=0 until reset. Non-trap build: one cycle `controlWord`=29'h0800_0000, then FETCH.
- `reset` asserted during MEMWAIT -> next edge returns to FETCH with `mem_req`=0 and no write.

Source files
------------

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: holds the IR, classifies its opcode and gates decoder-bank control words.
// Optional feature: define CU_ILLEGAL_TRAP_EN to make illegal opcodes halt instead of executing as a NOP.
module control_sequencer #(
    parameter int CW_W = 29
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     instr_in,
    input  logic            instr_valid,
    output logic            fetch_req,
    output logic [31:0]     instruction,
    output logic [2:0]      op_class,
    output logic [1:0]      state,
    input  logic [CW_W-1:0] dec_cw,
    input  logic [1:0]      dec_ns,
    input  logic [63:0]     dec_k,
    output logic            mem_req,
    input  logic            mem_ready,
    output logic [CW_W-1:0] controlWord,
    output logic [63:0]     K,
    output logic            halted
);

    localparam int PSEL_HI = 28;
    localparam int PSEL_LO = 27;
    localparam int REGW    = 6;
    localparam int RAMW    = 5;
    localparam int DSEL_HI = 4;
    localparam int DSEL_LO = 3;

    localparam logic [2:0] C_ILLEGAL = 3'd0;
    localparam logic [2:0] C_R       = 3'd1;
    localparam logic [2:0] C_I       = 3'd2;
    localparam logic [2:0] C_D       = 3'd3;
    localparam logic [2:0] C_B       = 3'd4;
    localparam logic [2:0] C_CB      = 3'd5;
    localparam logic [2:0] C_IW      = 3'd6;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        EXEC    = 2'd1,
        MEMWAIT = 2'd2,
        HALT    = 2'd3
    } fsm_t;

    fsm_t fsm;
    logic legal;
    logic is_mem;
    logic last_step;

    // First match wins; order matters because the opcode fields overlap.
    always_comb begin
        op_class = C_ILLEGAL;
        if (instruction[28:23] == 6'b100010)
            op_class = C_I;
        else if (instruction[28:23] == 6'b100101)
            op_class = C_IW;
        else if (instruction[29:24] == 6'b111000)
            op_class = C_D;
        else if (instruction[28:25] == 4'b0101)
            op_class = C_R;
        else if (instruction[30:26] == 5'b00101)
            op_class = C_B;
        else if (instruction[30:25] == 6'b011010)
            op_class = C_CB;
    end

    assign legal     = (op_class != C_ILLEGAL);
    assign is_mem    = dec_cw[RAMW] || (dec_cw[DSEL_HI:DSEL_LO] == 2'b10);
    assign last_step = (dec_ns == 2'd0);
    assign fetch_req = (fsm == FETCH);

`ifdef CU_ILLEGAL_TRAP_EN
    assign halted = (fsm == HALT);
`else
    assign halted = 1'b0;
`endif

    // Writes and PC advance are only allowed on the completing cycle of a step.
    always_comb begin
        controlWord = '0;
        K           = '0;
        mem_req     = 1'b0;
        case (fsm)
            EXEC: begin
                if (!legal) begin
`ifndef CU_ILLEGAL_TRAP_EN
                    controlWord[PSEL_HI:PSEL_LO] = 2'b01;
`endif
                end else if (is_mem) begin
                    mem_req     = 1'b1;
                    controlWord = dec_cw;
                    K           = dec_k;
                    controlWord[PSEL_HI:PSEL_LO] = 2'b00;
                    controlWord[REGW] = 1'b0;
                    controlWord[RAMW] = 1'b0;
                end else begin
                    controlWord = dec_cw;
                    K           = dec_k;
                    if (!last_step)
                        controlWord[PSEL_HI:PSEL_LO] = 2'b00;
                end
            end
            MEMWAIT: begin
                mem_req     = 1'b1;
                controlWord = dec_cw;
                K           = dec_k;
                if (!mem_ready) begin
                    controlWord[PSEL_HI:PSEL_LO] = 2'b00;
                    controlWord[REGW] = 1'b0;
                    controlWord[RAMW] = 1'b0;
                end else if (!last_step) begin
                    controlWord[PSEL_HI:PSEL_LO] = 2'b00;
                end
            end
            default: ;
        endcase
        // A cycle cut short by reset must not commit anything.
        if (reset) begin
            controlWord[PSEL_HI:PSEL_LO] = 2'b00;
            controlWord[REGW] = 1'b0;
            controlWord[RAMW] = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm         <= FETCH;
            instruction <= '0;
            state       <= '0;
        end else begin
            case (fsm)
                FETCH: begin
                    if (instr_valid) begin
                        instruction <= instr_in;
                        state       <= '0;
                        fsm         <= EXEC;
                    end
                end
                EXEC: begin
                    if (!legal) begin
`ifdef CU_ILLEGAL_TRAP_EN
                        fsm <= HALT;
`else
                        fsm <= FETCH;
`endif
                    end else if (is_mem) begin
                        fsm <= MEMWAIT;
                    end else if (last_step) begin
                        fsm <= FETCH;
                    end else begin
                        state <= dec_ns;
                    end
                end
                MEMWAIT: begin
                    if (mem_ready) begin
                        if (last_step) begin
                            fsm <= FETCH;
                        end else begin
                            state <= dec_ns;
                            fsm   <= EXEC;
                        end
                    end
                end
                HALT: ;
                default: fsm <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer; the bench plays the decoder bank and the data RAM.
// Honours CU_ILLEGAL_TRAP_EN the same way the design does.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instr_in;
    logic        instr_valid;
    logic        fetch_req;
    logic [31:0] instruction;
    logic [2:0]  op_class;
    logic [1:0]  state;
    logic [28:0] dec_cw;
    logic [1:0]  dec_ns;
    logic [63:0] dec_k;
    logic        mem_req;
    logic        mem_ready;
    logic [28:0] controlWord;
    logic [63:0] K;
    logic        halted;

    int total = 0;
    int bad   = 0;

    // Field layout: Psel DA SA SB Fsel regW ramW Dsel Bsel PCsel SL
    localparam logic [28:0] CW_ADDI = {2'b01, 5'd1, 5'd2, 5'd0, 5'd4, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
    localparam logic [28:0] CW_ST   = {2'b01, 5'd0, 5'd4, 5'd3, 5'd2, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0};
    localparam logic [28:0] CW_ST_G = {2'b00, 5'd0, 5'd4, 5'd3, 5'd2, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
    localparam logic [28:0] CW_LD   = {2'b01, 5'd3, 5'd4, 5'd0, 5'd2, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0};
    localparam logic [28:0] CW_LD_G = {2'b00, 5'd3, 5'd4, 5'd0, 5'd2, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0};
    localparam logic [28:0] CW_LD_P = {2'b00, 5'd3, 5'd4, 5'd0, 5'd2, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0};
    localparam logic [28:0] CW_S1   = {2'b10, 5'd0, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0};
    localparam logic [28:0] CW_S1_G = {2'b00, 5'd0, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0};
    localparam logic [28:0] CW_S2   = {2'b01, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};

    control_sequencer #(.CW_W(29)) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .fetch_req   (fetch_req),
        .instruction (instruction),
        .op_class    (op_class),
        .state       (state),
        .dec_cw      (dec_cw),
        .dec_ns      (dec_ns),
        .dec_k       (dec_k),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .controlWord (controlWord),
        .K           (K),
        .halted      (halted)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ins);
        instr_in    = ins;
        instr_valid = 1'b1;
        #1;
        chk("fetch_cw", controlWord, 0);
        chk("fetch_req", fetch_req, 1);
        tick();
        instr_valid = 1'b0;
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        instr_in    = '0;
        instr_valid = 1'b0;
        dec_cw      = '0;
        dec_ns      = '0;
        dec_k       = '0;
        mem_ready   = 1'b0;
        tick();
        tick();
        chk("rst_fetch_req", fetch_req, 1);
        chk("rst_cw", controlWord, 0);
        chk("rst_k", K, 0);
        chk("rst_halted", halted, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_state", state, 0);
        reset = 1'b0;

        // ADDI X1,X2,#5
        dec_cw = CW_ADDI;
        dec_k  = 64'd5;
        dec_ns = 2'd0;
        fetch(32'h9100_1441);
        chk("addi_ir", instruction, 32'h9100_1441);
        chk("addi_class", op_class, 2);
        chk("addi_state", state, 0);
        chk("addi_fetch_req", fetch_req, 0);
        chk("addi_cw", controlWord, CW_ADDI);
        chk("addi_k", K, 5);
        chk("addi_mem_req", mem_req, 0);
        tick();
        chk("addi_back_fetch", fetch_req, 1);
        chk("addi_back_cw", controlWord, 0);

        // STUR X3,[X4,#8]; mem_ready in EXEC must be ignored
        dec_cw = CW_ST;
        dec_k  = 64'd8;
        fetch(32'hF800_8083);
        mem_ready = 1'b1;
        #1;
        chk("st_class", op_class, 3);
        chk("st_exec_mem_req", mem_req, 1);
        chk("st_exec_cw", controlWord, CW_ST_G);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("st_w1_mem_req", mem_req, 1);
        chk("st_w1_cw", controlWord, CW_ST_G);
        chk("st_w1_fetch_req", fetch_req, 0);
        tick();
        chk("st_w2_mem_req", mem_req, 1);
        chk("st_w2_cw", controlWord, CW_ST_G);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("st_w3_mem_req", mem_req, 1);
        chk("st_w3_cw", controlWord, CW_ST);
        chk("st_w3_k", K, 8);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("st_done_mem_req", mem_req, 0);
        chk("st_done_fetch_req", fetch_req, 1);

        // Two-step R-class ADD
        dec_cw = CW_S1;
        dec_ns = 2'd1;
        dec_k  = 64'h1234;
        fetch(32'h8B02_0020);
        chk("two_class", op_class, 1);
        chk("two_s0_state", state, 0);
        chk("two_s0_cw", controlWord, CW_S1_G);
        tick();
        dec_cw = CW_S2;
        dec_ns = 2'd0;
        #1;
        chk("two_s1_state", state, 1);
        chk("two_s1_fetch_req", fetch_req, 0);
        chk("two_s1_cw", controlWord, CW_S2);
        tick();
        chk("two_done_fetch_req", fetch_req, 1);

        // Load step with a follow-on step: Psel held at 0 on the ready cycle
        dec_cw = CW_LD;
        dec_ns = 2'd1;
        fetch(32'hF840_0083);
        chk("ld_exec_cw", controlWord, CW_LD_G);
        chk("ld_exec_mem_req", mem_req, 1);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("ld_ready_cw", controlWord, CW_LD_P);
        tick();
        mem_ready = 1'b0;
        dec_cw = CW_ADDI;
        dec_ns = 2'd0;
        #1;
        chk("ld_s1_state", state, 1);
        chk("ld_s1_mem_req", mem_req, 0);
        chk("ld_s1_cw", controlWord, CW_ADDI);
        tick();
        chk("ld_done_fetch_req", fetch_req, 1);

        // Reset during MEMWAIT, with mem_ready also high
        dec_cw = CW_ST;
        fetch(32'hF800_8083);
        tick();
        chk("rmw_mem_req", mem_req, 1);
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("rmw_no_write", controlWord, CW_ST_G);
        tick();
        reset     = 1'b0;
        mem_ready = 1'b0;
        chk("rmw_fetch_req", fetch_req, 1);
        chk("rmw_mem_req_after", mem_req, 0);
        chk("rmw_cw_after", controlWord, 0);
        chk("rmw_ir_after", instruction, 0);

        // Illegal opcode
        dec_cw = CW_ADDI;
        dec_k  = 64'hDEAD;
        dec_ns = 2'd0;
        fetch(32'h0000_0000);
        chk("ill_class", op_class, 0);
        chk("ill_k", K, 0);
        chk("ill_halted_exec", halted, 0);
`ifdef CU_ILLEGAL_TRAP_EN
        chk("ill_cw", controlWord, 0);
        tick();
        instr_in    = 32'h9100_1441;
        instr_valid = 1'b1;
        tick();
        tick();
        instr_valid = 1'b0;
        #1;
        chk("ill_halted", halted, 1);
        chk("ill_halt_cw", controlWord, 0);
        chk("ill_halt_k", K, 0);
        chk("ill_halt_fetch_req", fetch_req, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("ill_reset_halted", halted, 0);
        chk("ill_reset_fetch_req", fetch_req, 1);
`else
        chk("ill_cw", controlWord, 29'h0800_0000);
        tick();
        chk("ill_fetch_req", fetch_req, 1);
        chk("ill_halted", halted, 0);
        chk("ill_after_cw", controlWord, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
